demux_scheduler: RTL



---
 rtl/demux_scheduler_pkg.sv | 21 ++
 rtl/demux_scheduler_rr_pick.sv | 39 +++
 rtl/demux_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/demux_scheduler_pkg.sv
// ============================================================================
// Module : demux_scheduler_pkg
// Brief  : Shared constants for the 1:4 demux sequencer: channel count,
//          select width and FSM state encodings.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_scheduler_pkg;

    localparam int c_N_CH  = 4;
    localparam int c_SEL_W = 2;

    // FSM state encodings
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_PICK = 2'd1;
    localparam logic [1:0] c_ST_SEND = 2'd2;

endpackage

`default_nettype wire

// File: rtl/demux_scheduler_rr_pick.sv
// ============================================================================
// Module : demux_scheduler_rr_pick
// Brief  : Combinational round-robin arbiter. Searches last_grant+1 .. +4
//          (mod 4) for the first enabled channel, so the previous winner is
//          only re-granted when it is the sole enabled channel.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_scheduler_rr_pick
    import demux_scheduler_pkg::*;
(
    input  logic [c_N_CH-1:0]  mask,
    input  logic [c_SEL_W-1:0] last_grant,
    output logic [c_SEL_W-1:0] grant,
    output logic               any
);

    logic [c_SEL_W-1:0] w_idx;
    logic               w_found;

    // Rotating priority search starting just after the previous grant
    always_comb begin
        grant   = last_grant;
        w_idx   = last_grant;
        w_found = 1'b0;
        for (int k = 1; k <= c_N_CH; k++) begin
            w_idx = last_grant + c_SEL_W'(k);
            if (!w_found && mask[w_idx]) begin
                grant   = w_idx;
                w_found = 1'b1;
            end
        end
        any = |mask;
    end

endmodule

`default_nettype wire

// File: rtl/demux_scheduler.sv
// ============================================================================
// Module : demux_scheduler
// Brief  : Sequencer for a 1:4 data demultiplexer. Buffers one input word and
//          steers it to the granted channel, delivering BURST words per
//          channel in round-robin order over the enabled channels.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_scheduler
    import demux_scheduler_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [c_N_CH-1:0]   mask,
    output logic [WIDTH-1:0]    out_data,
    output logic [c_N_CH-1:0]   out_valid,
    input  logic [c_N_CH-1:0]   out_ready,
    output logic [c_SEL_W-1:0]  sel,
    output logic                busy,
    output logic                burst_done
);

    localparam int                 c_CNT_W    = $clog2(BURST + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BURST - 1);

    logic [1:0]          r_state;
    logic                r_buf_full;
    logic [WIDTH-1:0]    r_buf;
    logic [c_SEL_W-1:0]  r_sel;
    logic [c_SEL_W-1:0]  r_last_grant;
    logic [c_CNT_W-1:0]  r_burst_cnt;
    logic                r_burst_done;

    logic [c_N_CH-1:0]   w_out_valid;
    logic                w_out_fire;
    logic                w_in_ready;
    logic                w_in_fire;
    logic [c_SEL_W-1:0]  w_grant;
    logic                w_any;

    demux_scheduler_rr_pick u_rr_pick (
        .mask       (mask),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .any        (w_any)
    );

    // One-hot valid to the granted channel only while a word is held in SEND
    always_comb begin
        w_out_valid = '0;
        if (r_state == c_ST_SEND && r_buf_full) begin
            w_out_valid[r_sel] = 1'b1;
        end
    end

    // Accepting while the buffer drains keeps a sustained 1 word/cycle
    assign w_out_fire = w_out_valid[r_sel] & out_ready[r_sel];
    assign w_in_ready = ~r_buf_full | w_out_fire;
    assign w_in_fire  = in_valid & w_in_ready;

    // One-entry holding buffer; a simultaneous fill and drain keeps it full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (w_in_fire) begin
            r_buf      <= in_data;
            r_buf_full <= 1'b1;
        end else if (w_out_fire) begin
            r_buf_full <= 1'b0;
        end
    end

    // Grant sequencing: IDLE -> PICK -> SEND bursts, re-arbitrating in PICK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_sel        <= '0;
            r_last_grant <= 2'd3;
            r_burst_cnt  <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_burst_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (|mask) begin
                        r_state <= c_ST_PICK;
                    end
                end
                c_ST_PICK: begin
                    if (!w_any) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_sel        <= w_grant;
                        r_last_grant <= w_grant;
                        r_burst_cnt  <= '0;
                        r_state      <= c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    if (w_out_fire) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                        if (r_burst_cnt == c_CNT_LAST) begin
                            r_burst_done <= 1'b1;
                            r_state      <= c_ST_PICK;
                        end else if (!mask[r_sel]) begin
                            // Committed word delivered to a now-disabled channel
                            r_state <= c_ST_PICK;
                        end
                    end else if (!mask[r_sel] && !r_buf_full) begin
                        r_state <= c_ST_PICK;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_data   = r_buf;
    assign out_valid  = w_out_valid;
    assign sel        = r_sel;
    assign busy       = (r_state != c_ST_IDLE);
    assign burst_done = r_burst_done;

endmodule

`default_nettype wire
